rr_decode_arbiter: RTL and testbench

- 8-way round-robin arbiter that shares one downstream resource slot among 8 requesters.
- Selects a winner index (3 bits), holds it for a bounded tenure, and drives the decoded one-hot grant vector: index 0 maps to bit 0, and so on up to index 7 mapping to bit 7.
- Sits between the requester bank and the 3-to-8 decode stage. It sequences which select code is presented, and when.

---
 rtl/rr_decode_arbiter.sv | 109 ++++++++++
 tb/tb_rr_decode_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 8-way round-robin arbiter with bounded tenure.
// Presents one owner at a time to the downstream 3-to-8 decode stage.
// Each grant is followed by a one-cycle gap (break-before-make), and the
// owner loses the grant after MAX_HOLD cycles.
// MAX_HOLD must be in 1..15 and must fit in CNT_W bits.
module rr_decode_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req,
   input  logic             done,
   output logic [7:0]       gnt,
   output logic [2:0]       gnt_idx,
   output logic             gnt_valid,
   output logic [CNT_W-1:0] tenure_cnt
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t           r_state;
   logic [2:0]       r_ptr;
   logic [7:0]       r_gnt;
   logic [2:0]       r_gnt_idx;
   logic             r_gnt_valid;
   logic [CNT_W-1:0] r_tenure;

   logic [2:0]       w_win;
   logic             w_found;
   logic [2:0]       w_cand;
   logic             w_release;

   // Winner search: first set request at or after r_ptr, wrapping 7 -> 0
   always_comb begin
      w_win   = r_ptr;
      w_found = 1'b0;
      w_cand  = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w_cand = r_ptr + 3'(i);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   // Release conditions; several may fire together and count as one release
   always_comb begin
      w_release = done || !req[r_gnt_idx] || (r_tenure == CNT_W'(MAX_HOLD));
   end

   // Arbitration FSM with registered grant outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_gnt_idx   <= '0;
         r_gnt_valid <= 1'b0;
         r_tenure    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state     <= S_GRANT;
                  r_gnt_idx   <= w_win;
                  r_gnt       <= 8'b1 << w_win;
                  r_gnt_valid <= 1'b1;
                  r_tenure    <= CNT_W'(1);
               end
            end
            S_GRANT: begin
               if (w_release) begin
                  r_state     <= S_IDLE;
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_tenure    <= '0;
                  r_ptr       <= r_gnt_idx + 3'd1;
               end else begin
                  r_tenure    <= r_tenure + CNT_W'(1);
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_gnt       <= '0;
               r_gnt_valid <= 1'b0;
               r_tenure    <= '0;
            end
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign gnt_idx    = r_gnt_idx;
   assign gnt_valid  = r_gnt_valid;
   assign tenure_cnt = r_tenure;

   // Output invariants
   a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
   a_idx_match: assert property (@(posedge clk) disable iff (rst)
      r_gnt_valid |-> (r_gnt == (8'b1 << r_gnt_idx)));
   a_valid_or: assert property (@(posedge clk) disable iff (rst) r_gnt_valid == (|r_gnt));
   a_tenure_max: assert property (@(posedge clk) disable iff (rst) r_tenure <= CNT_W'(MAX_HOLD));

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter (MAX_HOLD = 4), plus a random soak
// that checks the output invariants and the worst-case wait bound.
module tb_rr_decode_arbiter;

   localparam int HOLD  = 4;
   localparam int CW    = 4;
   localparam int BOUND = 7 * (HOLD + 1) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    req;
   logic          done;
   logic [7:0]    gnt;
   logic [2:0]    gnt_idx;
   logic          gnt_valid;
   logic [CW-1:0] tenure_cnt;

   int total = 0;
   int bad   = 0;

   rr_decode_arbiter #(.MAX_HOLD(HOLD), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .done       (done),
      .gnt        (gnt),
      .gnt_idx    (gnt_idx),
      .gnt_valid  (gnt_valid),
      .tenure_cnt (tenure_cnt)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      req  = 8'h00;
      done = 1'b0;
      rst  = 1'b1;
      step();
      step();
      rst  = 1'b0;
      step();
   endtask

   task automatic test_reset();
      req  = 8'h00;
      done = 1'b0;
      rst  = 1'b1;
      #3;
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || tenure_cnt !== 4'd0) begin
         bad++;
         $display("FAIL reset_state: gnt=%h valid=%b idx=%0d ten=%0d want 00/0/0/0",
                  gnt, gnt_valid, gnt_idx, tenure_cnt);
      end
      step();
      rst = 1'b0;
      step();
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_req: gnt=%h valid=%b want 00/0", gnt, gnt_valid);
      end
   endtask

   task automatic test_single();
      logic [3:0] exp_t;
      reset_dut();
      req = 8'h20;
      for (int t = 1; t <= 4; t++) begin
         step();
         exp_t = 4'(t);
         total++;
         if (gnt !== 8'h20 || gnt_idx !== 3'd5 || gnt_valid !== 1'b1 || tenure_cnt !== exp_t) begin
            bad++;
            $display("FAIL single_grant_t%0d: gnt=%h idx=%0d valid=%b ten=%0d want 20/5/1/%0d",
                     t, gnt, gnt_idx, gnt_valid, tenure_cnt, t);
         end
      end
      step();
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || tenure_cnt !== 4'd0) begin
         bad++;
         $display("FAIL single_forced_release: gnt=%h valid=%b ten=%0d want 00/0/0",
                  gnt, gnt_valid, tenure_cnt);
      end
      step();
      total++;
      if (gnt !== 8'h20 || gnt_idx !== 3'd5 || tenure_cnt !== 4'd1) begin
         bad++;
         $display("FAIL single_regrant: gnt=%h idx=%0d ten=%0d want 20/5/1", gnt, gnt_idx, tenure_cnt);
      end
      req = 8'h00;
      step();
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_withdraw: gnt=%h valid=%b want 00/0", gnt, gnt_valid);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] exp_g;
      reset_dut();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         exp_g = 8'h01 << (k % 8);
         step();
         total++;
         if (gnt !== exp_g || gnt_idx !== 3'(k % 8) || tenure_cnt !== 4'd1) begin
            bad++;
            $display("FAIL rotation_grant%0d: gnt=%h idx=%0d ten=%0d want %h/%0d/1",
                     k, gnt, gnt_idx, tenure_cnt, exp_g, k % 8);
         end
         step();
         total++;
         if (gnt !== exp_g || tenure_cnt !== 4'd2) begin
            bad++;
            $display("FAIL rotation_hold%0d: gnt=%h ten=%0d want %h/2", k, gnt, tenure_cnt, exp_g);
         end
         done = 1'b1;
         step();
         done = 1'b0;
         total++;
         if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL rotation_gap%0d: gnt=%h valid=%b want 00/0", k, gnt, gnt_valid);
         end
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_wrap();
      reset_dut();
      req = 8'h40;
      step();
      total++;
      if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
         bad++;
         $display("FAIL wrap_first6: gnt=%h idx=%0d want 40/6", gnt, gnt_idx);
      end
      req = 8'h00;
      step();
      req = 8'h41;
      step();
      total++;
      if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
         bad++;
         $display("FAIL wrap_to0: gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      total++;
      if (gnt !== 8'h00) begin
         bad++;
         $display("FAIL wrap_gap: gnt=%h want 00", gnt);
      end
      step();
      total++;
      if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
         bad++;
         $display("FAIL wrap_then6: gnt=%h idx=%0d want 40/6", gnt, gnt_idx);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_overlap();
      reset_dut();
      req = 8'h18;
      step();
      total++;
      if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
         bad++;
         $display("FAIL overlap_owner3: gnt=%h idx=%0d want 08/3", gnt, gnt_idx);
      end
      // owner withdraws and signals done in the same cycle; req[2] is a
      // decoy that would win if the pointer had not moved to 4
      req  = 8'h14;
      done = 1'b1;
      step();
      done = 1'b0;
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || tenure_cnt !== 4'd0) begin
         bad++;
         $display("FAIL overlap_release: gnt=%h valid=%b ten=%0d want 00/0/0", gnt, gnt_valid, tenure_cnt);
      end
      step();
      total++;
      if (gnt !== 8'h10 || gnt_idx !== 3'd4 || tenure_cnt !== 4'd1) begin
         bad++;
         $display("FAIL overlap_next4: gnt=%h idx=%0d ten=%0d want 10/4/1", gnt, gnt_idx, tenure_cnt);
      end
      step();
      total++;
      if (gnt !== 8'h10 || tenure_cnt !== 4'd2) begin
         bad++;
         $display("FAIL overlap_single_release: gnt=%h ten=%0d want 10/2", gnt, tenure_cnt);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      req = 8'h04;
      step();
      step();
      total++;
      if (gnt !== 8'h04 || tenure_cnt !== 4'd2) begin
         bad++;
         $display("FAIL midrst_setup: gnt=%h ten=%0d want 04/2", gnt, tenure_cnt);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || tenure_cnt !== 4'd0) begin
         bad++;
         $display("FAIL midrst_async: gnt=%h valid=%b ten=%0d want 00/0/0", gnt, gnt_valid, tenure_cnt);
      end
      #2 rst = 1'b0;
      req = 8'h0C;
      step();
      total++;
      if (gnt !== 8'h04 || gnt_idx !== 3'd2 || tenure_cnt !== 4'd1) begin
         bad++;
         $display("FAIL midrst_regrant: gnt=%h idx=%0d ten=%0d want 04/2/1", gnt, gnt_idx, tenure_cnt);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_done_idle();
      reset_dut();
      done = 1'b1;
      step();
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
         bad++;
         $display("FAIL done_idle_nogrant: gnt=%h valid=%b want 00/0", gnt, gnt_valid);
      end
      // done still high while a request arrives: grant still issued from IDLE
      req = 8'h80;
      step();
      done = 1'b0;
      total++;
      if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
         bad++;
         $display("FAIL done_idle_grant: gnt=%h idx=%0d want 80/7", gnt, gnt_idx);
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_soak();
      int         wait_cnt [8];
      logic [7:0] nreq;
      logic [7:0] exp_g;
      reset_dut();
      for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         exp_g = 8'h01 << gnt_idx;
         total++;
         if (!$onehot0(gnt)) begin
            bad++;
            $display("FAIL soak_onehot c%0d: gnt=%h want zero or one-hot", c, gnt);
         end
         total++;
         if (gnt_valid !== (|gnt)) begin
            bad++;
            $display("FAIL soak_valid c%0d: valid=%b want %b", c, gnt_valid, |gnt);
         end
         total++;
         if (gnt_valid && gnt !== exp_g) begin
            bad++;
            $display("FAIL soak_idx c%0d: gnt=%h want %h", c, gnt, exp_g);
         end
         total++;
         if (tenure_cnt > 4'(HOLD)) begin
            bad++;
            $display("FAIL soak_tenure c%0d: ten=%0d want <=%0d", c, tenure_cnt, HOLD);
         end
         for (int i = 0; i < 8; i++) begin
            if (req[i] && !gnt[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            total++;
            if (wait_cnt[i] > BOUND) begin
               bad++;
               $display("FAIL soak_wait c%0d: req%0d waited %0d want <=%0d", c, i, wait_cnt[i], BOUND);
            end
         end
         // requesters hold req until served; a served one may drop it
         nreq = req;
         for (int i = 0; i < 8; i++) begin
            if (req[i] && gnt[i] && ($urandom_range(1, 0) == 1)) nreq[i] = 1'b0;
            else if (!req[i] && ($urandom_range(9, 0) < 3)) nreq[i] = 1'b1;
         end
         req  = nreq;
         done = ($urandom_range(3, 0) == 0);
      end
      req  = 8'h00;
      done = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst  = 1'b0;
      req  = 8'h00;
      done = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_overlap();
      test_reset_mid();
      test_done_idle();
      test_soak();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
